data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_if.sv | 21 ++
 rtl/data_mem_responder.sv | 89 ++++++++
 tb/tb_data_mem_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: load/store request and response channels between core and data memory
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_size, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_size, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory answering RISC-V B/H/W loads and stores
// after a fixed latency, with alignment/range errors reported instead of performed.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic clk,
    input logic reset_n,
    data_mem_responder_if.slave bus
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic        c_write;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [2:0]  c_size;
    logic [31:0] mem [DEPTH_WORDS];
    logic        err;
    logic [AW-1:0] idx;
    logic [31:0] word;
    logic [15:0] sh;
    logic [31:0] ld;
    logic [31:0] wsh;
    logic [3:0]  be;
    logic        do_acc;
    always_comb begin
        err = c_size[1:0] == 2'b11 || c_size == 3'b110 || (c_write && c_size[2])
            || (c_size[1:0] == 2'b01 && c_addr[0])
            || (c_size[1:0] == 2'b10 && c_addr[1:0] != 2'b00)
            || c_addr[31:2] >= 30'(DEPTH_WORDS);
        idx = c_addr[AW+1:2];
        word = mem[idx];
        sh = 16'(word >> {c_addr[1:0], 3'b000});
        ld = c_size[1:0] == 2'b00 ? {{24{sh[7] & ~c_size[2]}}, sh[7:0]}
           : c_size[1:0] == 2'b01 ? {{16{sh[15] & ~c_size[2]}}, sh[15:0]} : word;
        wsh = c_wdata << {c_addr[1:0], 3'b000};
        be = c_size[1:0] == 2'b00 ? 4'b0001 << c_addr[1:0]
           : c_size[1:0] == 2'b01 ? 4'b0011 << c_addr[1:0] : 4'b1111;
        do_acc = state == WAIT && cnt == 4'd0;
    end
    // Memory is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (do_acc && !err && c_write)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
    end
    // A zero-wait build still spends one edge in WAIT so the access always uses captured fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            bus.req_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_error <= 1'b0;
            c_write <= 1'b0;
            c_addr <= '0;
            c_wdata <= '0;
            c_size <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    c_write <= bus.req_write;
                    c_addr <= bus.req_addr;
                    c_wdata <= bus.req_wdata;
                    c_size <= bus.req_size;
                    cnt <= WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : 4'd0;
                    state <= WAIT;
                    bus.req_ready <= 1'b0;
                end
                WAIT: if (cnt == 4'd0) begin
                    state <= RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_error <= err;
                    bus.rsp_rdata <= err || c_write ? 32'd0 : ld;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: if (bus.rsp_ready) begin
                    state <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: vector table against a 2-wait instance, plus stall, reset
// and zero-wait sequences.
module tb_data_mem_responder;
    logic clk = 1'b0;
    logic reset_n;
    int total = 0;
    int bad = 0;
    data_mem_responder_if a ();
    data_mem_responder_if b ();
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_a (.clk(clk), .reset_n(reset_n), .bus(a));
    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_b (.clk(clk), .reset_n(reset_n), .bus(b));
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [2:0]  sz;
        logic [31:0] rd;
        logic        er;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic w, logic [31:0] ad, logic [31:0] wd, logic [2:0] sz,
                                logic [31:0] rd, logic er);
        vec_t v;
        v.w = w; v.ad = ad; v.wd = wd; v.sz = sz; v.rd = rd; v.er = er;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic xfer(input bit sel, input logic w, input logic [31:0] ad, input logic [31:0] wd,
                        input logic [2:0] sz, output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        a.req_write = w; a.req_addr = ad; a.req_wdata = wd; a.req_size = sz;
        b.req_write = w; b.req_addr = ad; b.req_wdata = wd; b.req_size = sz;
        a.req_valid = !sel; b.req_valid = sel;
        @(posedge clk); #1;
        a.req_valid = 1'b0; b.req_valid = 1'b0;
        lat = 0;
        while (!(sel ? b.rsp_valid : a.rsp_valid) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = sel ? b.rsp_rdata : a.rsp_rdata;
        er = sel ? b.rsp_error : a.rsp_error;
        a.rsp_ready = 1'b1; b.rsp_ready = 1'b1;
        @(posedge clk); #1;
        a.rsp_ready = 1'b0; b.rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic er;
        int lat;
        a.req_valid = 0; a.req_write = 0; a.req_addr = 0; a.req_wdata = 0; a.req_size = 0; a.rsp_ready = 0;
        b.req_valid = 0; b.req_write = 0; b.req_addr = 0; b.req_wdata = 0; b.req_size = 0; b.rsp_ready = 0;
        reset_n = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        chk("rst_ready", 32'(a.req_ready), 32'd1);
        chk("rst_valid", 32'(a.rsp_valid), 32'd0);
        chk("rst_rdata", a.rsp_rdata, 32'd0);
        chk("rst_error", 32'(a.rsp_error), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        add(1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        0);
        add(0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0);
        add(0, 32'h13,  32'h0,        3'b000, 32'hFFFFFFDE, 0);
        add(0, 32'h13,  32'h0,        3'b100, 32'h000000DE, 0);
        add(0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 0);
        add(0, 32'h10,  32'h0,        3'b101, 32'h0000BEEF, 0);
        add(1, 32'h11,  32'hABCDEF55, 3'b000, 32'h0,        0);
        add(0, 32'h10,  32'h0,        3'b010, 32'hDEAD55EF, 0);
        add(0, 32'h12,  32'h0,        3'b010, 32'h0,        1);
        add(1, 32'h11,  32'h1234,     3'b001, 32'h0,        1);
        add(0, 32'h400, 32'h0,        3'b010, 32'h0,        1);
        add(0, 32'h10,  32'h0,        3'b010, 32'hDEAD55EF, 0);
        add(0, 32'h10,  32'h0,        3'b011, 32'h0,        1);
        add(1, 32'h10,  32'h99,       3'b100, 32'h0,        1);
        add(0, 32'h11,  32'h0,        3'b101, 32'h0,        1);
        add(0, 32'h10,  32'h0,        3'b111, 32'h0,        1);
        add(0, 32'h10,  32'h0,        3'b010, 32'hDEAD55EF, 0);
        add(1, 32'h14,  32'h11223344, 3'b010, 32'h0,        0);
        add(1, 32'h16,  32'hFFFF80FE, 3'b001, 32'h0,        0);
        add(0, 32'h14,  32'h0,        3'b010, 32'h80FE3344, 0);
        add(0, 32'h16,  32'h0,        3'b001, 32'hFFFF80FE, 0);
        add(0, 32'h16,  32'h0,        3'b101, 32'h000080FE, 0);
        add(0, 32'h15,  32'h0,        3'b000, 32'h00000033, 0);
        add(0, 32'h17,  32'h0,        3'b000, 32'hFFFFFF80, 0);
        add(1, 32'h3FC, 32'h0BADF00D, 3'b010, 32'h0,        0);
        add(0, 32'h3FC, 32'h0,        3'b010, 32'h0BADF00D, 0);
        add(0, 32'h3FD, 32'h0,        3'b100, 32'h000000F0, 0);
        foreach (tbl[i]) begin
            xfer(0, tbl[i].w, tbl[i].ad, tbl[i].wd, tbl[i].sz, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d_error", i), 32'(er), 32'(tbl[i].er));
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
        end

        // Response stall with garbage request inputs driven during WAIT/RESP.
        @(negedge clk);
        a.req_write = 0; a.req_addr = 32'h10; a.req_size = 3'b010; a.req_valid = 1;
        @(posedge clk); #1;
        a.req_write = 1; a.req_addr = 32'h10; a.req_wdata = 32'h0; a.req_size = 3'b010;
        lat = 0;
        while (!a.rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stall_lat", 32'(lat), 32'd2);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("stall%0d_valid", k), 32'(a.rsp_valid), 32'd1);
            chk($sformatf("stall%0d_rdata", k), a.rsp_rdata, 32'hDEAD55EF);
            chk($sformatf("stall%0d_ready", k), 32'(a.req_ready), 32'd0);
        end
        a.req_valid = 0; a.rsp_ready = 1;
        @(posedge clk); #1;
        a.rsp_ready = 0;
        chk("stall_exit_valid", 32'(a.rsp_valid), 32'd0);
        chk("stall_exit_ready", 32'(a.req_ready), 32'd1);
        xfer(0, 0, 32'h10, 0, 3'b010, rd, er, lat);
        chk("stall_after_rdata", rd, 32'hDEAD55EF);

        // Reset in WAIT abandons the store.
        xfer(0, 1, 32'h20, 32'hA5A5A5A5, 3'b010, rd, er, lat);
        @(negedge clk);
        a.req_write = 1; a.req_addr = 32'h20; a.req_wdata = 32'h12345678; a.req_size = 3'b010; a.req_valid = 1;
        @(posedge clk); #1;
        a.req_valid = 0;
        chk("wait_ready_low", 32'(a.req_ready), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("wrst_ready", 32'(a.req_ready), 32'd1);
        chk("wrst_valid", 32'(a.rsp_valid), 32'd0);
        chk("wrst_rdata", a.rsp_rdata, 32'd0);
        chk("wrst_error", 32'(a.rsp_error), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        xfer(0, 0, 32'h20, 0, 3'b010, rd, er, lat);
        chk("wrst_keep_rdata", rd, 32'hA5A5A5A5);

        // Reset in RESP keeps the performed store.
        @(negedge clk);
        a.req_write = 1; a.req_addr = 32'h24; a.req_wdata = 32'h00000077; a.req_size = 3'b010; a.req_valid = 1;
        @(posedge clk); #1;
        a.req_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("resp_valid_hi", 32'(a.rsp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rrst_valid", 32'(a.rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        xfer(0, 0, 32'h24, 0, 3'b010, rd, er, lat);
        chk("rrst_kept_rdata", rd, 32'h00000077);

        // Zero-wait instance.
        xfer(1, 1, 32'h8, 32'hCAFEF00D, 3'b010, rd, er, lat);
        chk("z_sw_lat", 32'(lat), 32'd1);
        chk("z_sw_error", 32'(er), 32'd0);
        xfer(1, 0, 32'h8, 0, 3'b010, rd, er, lat);
        chk("z_lw_lat", 32'(lat), 32'd1);
        chk("z_lw_rdata", rd, 32'hCAFEF00D);
        xfer(1, 0, 32'h9, 0, 3'b000, rd, er, lat);
        chk("z_lb_rdata", rd, 32'hFFFFFFF0);
        xfer(1, 0, 32'hA, 0, 3'b010, rd, er, lat);
        chk("z_err_rdata", rd, 32'd0);
        chk("z_err_error", 32'(er), 32'd1);
        chk("z_err_lat", 32'(lat), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
